// File: rtl/watch_set_ctrl.sv
// Time-setting controller: edit FSM with auto-repeat, idle abort,
// field blink and 12/24-hour digit display.
module watch_set_ctrl #(
   parameter int REPEAT_DELAY_CYC = 50_000_000,
   parameter int REPEAT_RATE_CYC  = 10_000_000,
   parameter int TIMEOUT_CYC      = 1_000_000_000,
   parameter int BLINK_HALF_CYC   = 25_000_000
) (
   input  logic       clk_100MHz_i,
   input  logic       reset_i,
   input  logic [5:0] seconds_i,
   input  logic [5:0] minutes_i,
   input  logic [4:0] hours_i,
   input  logic       btn_config_i,
   input  logic       btn_inc_i,
   input  logic       btn_dec_i,
   input  logic       mode_12h_i,
   output logic       count_enable_o,
   output logic [5:0] load_seconds_o,
   output logic [5:0] load_minutes_o,
   output logic [4:0] load_hours_o,
   output logic       load_time_o,
   output logic [1:0] edit_field_o,
   output logic       pm_o,
   output logic [5:0] d1,
   output logic [5:0] d2,
   output logic [5:0] d3,
   output logic [5:0] d4,
   output logic [5:0] d5,
   output logic [5:0] d6,
   output logic [5:0] d7,
   output logic [5:0] d8
);

   localparam int HMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                         REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
   localparam int HW = $clog2(HMAX + 1);
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int BW = $clog2(BLINK_HALF_CYC);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      EDIT_H = 2'd1,
      EDIT_M = 2'd2,
      EDIT_S = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic          cfg_q, inc_q, dec_q;
   logic [4:0]    e_h, e_h_nx;
   logic [5:0]    e_m, e_m_nx, e_s, e_s_nx;
   logic [HW-1:0] hold_q, hold_nx, hold_lim;
   logic          rep_q, rep_nx;
   logic [TW-1:0] idle_q, idle_nx;
   logic [BW-1:0] blink_q, blink_nx;
   logic          hide_q, hide_nx;
   logic          load_q, commit;
   logic          cfg_edge, inc_edge, dec_edge, any_edge;
   logic          editing, both, up, dn, step, tmo;

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

   always_ff @(posedge clk_100MHz_i) begin
      if (reset_i) begin
         state   <= RUN;
         cfg_q   <= 1'b0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         e_h     <= '0;
         e_m     <= '0;
         e_s     <= '0;
         hold_q  <= '0;
         rep_q   <= 1'b0;
         idle_q  <= '0;
         blink_q <= '0;
         hide_q  <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         cfg_q   <= btn_config_i;
         inc_q   <= btn_inc_i;
         dec_q   <= btn_dec_i;
         e_h     <= e_h_nx;
         e_m     <= e_m_nx;
         e_s     <= e_s_nx;
         hold_q  <= hold_nx;
         rep_q   <= rep_nx;
         idle_q  <= idle_nx;
         blink_q <= blink_nx;
         hide_q  <= hide_nx;
         load_q  <= commit;
      end
   end

   always_comb begin
      cfg_edge = btn_config_i & ~cfg_q;
      inc_edge = btn_inc_i & ~inc_q;
      dec_edge = btn_dec_i & ~dec_q;
      any_edge = cfg_edge | inc_edge | dec_edge;
      editing  = (state != RUN);
      both     = btn_inc_i & btn_dec_i;
      hold_lim = rep_q ? HW'(REPEAT_RATE_CYC) : HW'(REPEAT_DELAY_CYC);
      state_nx = state;
      hold_nx  = '0;
      rep_nx   = 1'b0;
      up       = 1'b0;
      dn       = 1'b0;
      commit   = 1'b0;
      // held button re-arms its counter on every step it fires
      if (editing && !both) begin
         if (inc_edge || dec_edge) begin
            up      = inc_edge;
            dn      = dec_edge;
            hold_nx = HW'(1);
         end else if (btn_inc_i || btn_dec_i) begin
            if (hold_q == hold_lim) begin
               up      = btn_inc_i;
               dn      = btn_dec_i;
               hold_nx = HW'(1);
               rep_nx  = 1'b1;
            end else begin
               hold_nx = hold_q + HW'(1);
               rep_nx  = rep_q;
            end
         end
      end
      if (cfg_edge) begin
         up = 1'b0;
         dn = 1'b0;
         unique case (state)
            RUN:    state_nx = EDIT_H;
            EDIT_H: state_nx = EDIT_M;
            EDIT_M: state_nx = EDIT_S;
            EDIT_S: state_nx = RUN;
            default: state_nx = RUN;
         endcase
         commit = (state == EDIT_S);
      end
      step = up | dn;
      tmo  = editing && !any_edge && !step &&
             (idle_q == TW'(TIMEOUT_CYC - 1));
      if (tmo) state_nx = RUN;
      if (!editing || any_edge || step || tmo) idle_nx = '0;
      else idle_nx = idle_q + TW'(1);
      blink_nx = '0;
      hide_nx  = 1'b0;
      if (state_nx != RUN && state_nx == state && !step) begin
         if (blink_q == BW'(BLINK_HALF_CYC - 1)) begin
            hide_nx = ~hide_q;
         end else begin
            blink_nx = blink_q + BW'(1);
            hide_nx  = hide_q;
         end
      end
      e_h_nx = e_h;
      e_m_nx = e_m;
      e_s_nx = e_s;
      if (!editing) begin
         e_h_nx = hours_i;
         e_m_nx = minutes_i;
         e_s_nx = seconds_i;
      end else if (step) begin
         unique case (state)
            EDIT_H:
               if (up) e_h_nx = (e_h == 5'd23) ? 5'd0 : e_h + 5'd1;
               else    e_h_nx = (e_h == 5'd0) ? 5'd23 : e_h - 5'd1;
            EDIT_M:
               if (up) e_m_nx = (e_m == 6'd59) ? 6'd0 : e_m + 6'd1;
               else    e_m_nx = (e_m == 6'd0) ? 6'd59 : e_m - 6'd1;
            default:
               if (up) e_s_nx = (e_s == 6'd59) ? 6'd0 : e_s + 6'd1;
               else    e_s_nx = (e_s == 6'd0) ? 6'd59 : e_s - 6'd1;
         endcase
      end
   end

   logic [4:0] src_h, disp_h;
   logic [5:0] src_m, src_s;
   logic [7:0] bh, bm, bs;
   logic       hid_h, hid_m, hid_s;

   always_comb begin
      src_h  = editing ? e_h : hours_i;
      src_m  = editing ? e_m : minutes_i;
      src_s  = editing ? e_s : seconds_i;
      disp_h = src_h;
      if (mode_12h_i) begin
         if (src_h == 5'd0)      disp_h = 5'd12;
         else if (src_h > 5'd12) disp_h = src_h - 5'd12;
      end
      bh    = to_bcd({1'b0, disp_h});
      bm    = to_bcd(src_m);
      bs    = to_bcd(src_s);
      hid_h = hide_q && (state == EDIT_H);
      hid_m = hide_q && (state == EDIT_M);
      hid_s = hide_q && (state == EDIT_S);
   end

   assign count_enable_o = (state == RUN);
   assign load_seconds_o = e_s;
   assign load_minutes_o = e_m;
   assign load_hours_o   = e_h;
   assign load_time_o    = load_q;
   assign edit_field_o   = state;
   assign pm_o           = mode_12h_i && (src_h >= 5'd12);
   assign d8 = {~hid_h, bh[7:4], 1'b1};
   assign d7 = {~hid_h, bh[3:0], 1'b1};
   assign d6 = 6'b000001;
   assign d5 = {~hid_m, bm[7:4], 1'b1};
   assign d4 = {~hid_m, bm[3:0], 1'b1};
   assign d3 = 6'b000001;
   assign d2 = {~hid_s, bs[7:4], 1'b1};
   assign d1 = {~hid_s, bs[3:0], 1'b1};

endmodule
